// File: rtl/logic_cluster_if.sv
// logic_cluster_if: serial configuration port of logic_cluster (load handshake and status)
interface logic_cluster_if;
  logic CFG_START;
  logic CFG_VLD;
  logic CFG_DI;
  logic CFG_BUSY;
  logic CFG_DONE;
  modport master (output CFG_START, CFG_VLD, CFG_DI, input CFG_BUSY, CFG_DONE);
  modport slave (input CFG_START, CFG_VLD, CFG_DI, output CFG_BUSY, CFG_DONE);
endinterface

// File: rtl/logic_cluster.sv
// logic_cluster: NUM_CELLS LUT/carry/FF cells with a double-buffered serial configuration chain; carry chain enabled by LOGIC_CLUSTER_CARRY_EN
module logic_cluster #(
  parameter int NUM_CELLS = 4,
  parameter int LUT_K = 4
) (
  input  logic                         QCK,
  input  logic                         QRTN,
  input  logic [NUM_CELLS*LUT_K-1:0]   LI,
  input  logic [NUM_CELLS-1:0]         QDI,
  input  logic [NUM_CELLS-1:0]         QEN,
  input  logic                         QST,
  input  logic                         QRT,
  input  logic                         CI,
  logic_cluster_if.slave               cfg,
  output logic [NUM_CELLS-1:0]         FZ,
  output logic [NUM_CELLS-1:0]         QZ,
  output logic                         CO
);
  localparam int T = 2**LUT_K;
  localparam int W = T + 2;
  localparam int CFG_BITS = NUM_CELLS * W;
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CFG_BITS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CFG_BITS);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [NUM_CELLS-1:0] qz_q, qz_d;
  logic [NUM_CELLS-1:0] cds;
  logic [NUM_CELLS-1:0] car;
  assign cfg.CFG_BUSY = busy_q;
  assign cfg.CFG_DONE = done_q;
  assign QZ = qz_q;
`ifdef LOGIC_CLUSTER_CARRY_EN
  logic [NUM_CELLS:0] cy;
  assign cy[0] = CI;
  assign CO = cy[NUM_CELLS];
`else
  logic unused_carry;
  assign unused_carry = ^{CI, car};
  assign CO = 1'b0;
`endif
  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    logic [T-1:0] lut;
    logic [LUT_K-1:0] li;
    assign lut = active_q[c*W +: T];
    assign cds[c] = active_q[c*W + T];
    assign car[c] = active_q[c*W + T + 1];
    assign li = LI[c*LUT_K +: LUT_K];
`ifdef LOGIC_CLUSTER_CARRY_EN
    assign FZ[c] = car[c] ? li[0] ^ li[1] ^ cy[c] : lut[li];
    assign cy[c+1] = car[c] & ((li[0] & li[1]) | (cy[c] & (li[0] ^ li[1])));
`else
    assign FZ[c] = lut[li];
`endif
  end
  // Cell flip-flop next state: sync reset beats sync set beats enable; data picked by CDS
  always_comb begin
    qz_d = qz_q;
    for (int i = 0; i < NUM_CELLS; i++)
      qz_d[i] = QRT ? 1'b0 : QST ? 1'b1 : QEN[i] ? (cds[i] ? QDI[i] : FZ[i]) : qz_q[i];
  end
  // Configuration loader: shift into shadow while running on active, then commit in one edge
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (cfg.CFG_START) begin
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (cfg.CFG_VLD) begin
        shadow_d = {cfg.CFG_DI, shadow_q[CFG_BITS-1:1]};
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? COMMIT : SHIFT;
      end
      COMMIT: begin
        active_d = shadow_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // All state registers; async reset discards any partial load and the active function
  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
      active_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      qz_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      busy_q <= busy_d;
      done_q <= done_d;
      qz_q <= qz_d;
    end
  end
endmodule

// File: tb/tb_logic_cluster.sv
// tb_logic_cluster: scoreboard bench for logic_cluster at default parameters
module tb_logic_cluster;
  typedef struct {
    string nm;
    int sel;
    logic [31:0] v;
  } chk_t;
  logic QCK = 1'b0;
  logic QRTN = 1'b1;
  logic [15:0] LI = '0;
  logic [3:0] QDI = '0;
  logic [3:0] QEN = '0;
  logic QST = 1'b0;
  logic QRT = 1'b0;
  logic CI = 1'b0;
  logic [3:0] FZ, QZ;
  logic CO;
  int checks = 0;
  int failures = 0;
  int n_edge = 0;
  chk_t sb[$];
  int dq[$];
  logic_cluster_if cif();
  logic_cluster dut (
    .QCK(QCK), .QRTN(QRTN), .LI(LI), .QDI(QDI), .QEN(QEN), .QST(QST), .QRT(QRT),
    .CI(CI), .cfg(cif), .FZ(FZ), .QZ(QZ), .CO(CO)
  );
  always #5 QCK = ~QCK;
  always @(posedge QCK) n_edge <= cif.CFG_START ? 1 : n_edge + 1;
  function automatic logic [31:0] act(input int sel);
    case (sel)
      0: return 32'(FZ);
      1: return 32'(QZ);
      2: return 32'(CO);
      3: return 32'(cif.CFG_BUSY);
      default: return 32'(cif.CFG_DONE);
    endcase
  endfunction
  always @(negedge QCK) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = sb.pop_front();
      a = act(c.sel);
      checks++;
      if (a !== c.v) begin
        failures++;
        $display("FAIL %s: got %0h want %0h", c.nm, a, c.v);
      end
    end
    if (cif.CFG_DONE === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: got CFG_DONE=1 want 0 (edge %0d)", n_edge);
      end else begin
        int e;
        e = dq.pop_front();
        if (n_edge != e) begin
          failures++;
          $display("FAIL done_latency: got %0d edges want %0d", n_edge, e);
        end
      end
    end
  end
  task automatic chk(input string nm, input int sel, input logic [31:0] v);
    sb.push_back('{nm, sel, v});
  endtask
  task automatic tick();
    @(posedge QCK);
    #1;
  endtask
  task automatic load(input logic [71:0] c, input bit tog);
    cif.CFG_START = 1'b1;
    dq.push_back(tog ? 146 : 74);
    chk("busy_before_start", 3, 0);
    tick();
    cif.CFG_START = 1'b0;
    chk("busy_shift", 3, 1);
    for (int i = 0; i < 72; i++) begin
      if (tog) begin
        cif.CFG_VLD = 1'b0;
        tick();
      end
      cif.CFG_VLD = 1'b1;
      cif.CFG_DI = c[i];
      tick();
    end
    cif.CFG_VLD = 1'b0;
    cif.CFG_DI = 1'b0;
    chk("busy_commit", 3, 1);
  endtask
  logic [71:0] c_and, c_or, c_carry, c_cds;
  initial begin
    c_and = 72'h8888;
    c_or = 72'hEEEE;
    c_carry = '0;
    c_cds = '0;
    for (int c = 0; c < 4; c++) begin
      c_carry[c*18+17] = 1'b1;
      c_cds[c*18+16] = 1'b1;
    end
    cif.CFG_START = 1'b0;
    cif.CFG_VLD = 1'b0;
    cif.CFG_DI = 1'b0;
    #2 QRTN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      LI = 16'($urandom);
      QDI = 4'($urandom);
      QEN = 4'($urandom);
      QST = 1'($urandom);
      QRT = 1'($urandom);
      CI = 1'($urandom);
      cif.CFG_START = 1'($urandom);
      cif.CFG_VLD = 1'($urandom);
      cif.CFG_DI = 1'($urandom);
      chk("rst_fz", 0, 0);
      chk("rst_qz", 1, 0);
      chk("rst_co", 2, 0);
      chk("rst_busy", 3, 0);
    end
    tick();
    QRTN = 1'b1;
    cif.CFG_START = 1'b0;
    cif.CFG_VLD = 1'b0;
    QST = 1'b0;
    QRT = 1'b0;
    QEN = 4'hF;
    QDI = 4'hF;
    tick();
    tick();
    chk("post_rst_qz", 1, 0);
    QEN = 4'h0;
    LI = 16'h0003;
    CI = 1'b0;
    load(c_and, 1'b0);
    chk("and_pre_commit_fz", 0, 0);
    tick();
    chk("and_fz", 0, 4'b0001);
    tick();
    chk("and_done_low", 4, 0);
    LI = 16'h0001;
    chk("and_fz_li1", 0, 0);
    tick();
    LI = 16'h0003;
    QEN = 4'h1;
    tick();
    chk("and_qz_from_fz", 1, 4'b0001);
    QEN = 4'h0;
    QRT = 1'b1;
    tick();
    QRT = 1'b0;
    chk("qrt_clear", 1, 0);
    LI = 16'h0001;
    QEN = 4'hF;
    load(c_or, 1'b1);
    chk("dbuf_pre_commit_fz", 0, 0);
    chk("dbuf_pre_commit_qz", 1, 0);
    tick();
    chk("dbuf_fz", 0, 4'b0001);
    chk("dbuf_commit_qz_old", 1, 0);
    tick();
    chk("dbuf_qz_new", 1, 4'b0001);
    chk("dbuf_done_low", 4, 0);
    LI = 16'h0000;
    chk("or_fz_li0", 0, 0);
    tick();
    QEN = 4'h0;
    LI = 16'h0001;
    chk("or_active_fz", 0, 4'b0001);
    cif.CFG_START = 1'b1;
    tick();
    cif.CFG_START = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cif.CFG_VLD = 1'b1;
      cif.CFG_DI = 1'b1;
      tick();
    end
    cif.CFG_VLD = 1'b0;
    chk("midload_busy", 3, 1);
    tick();
    QRTN = 1'b0;
    chk("midrst_busy", 3, 0);
    chk("midrst_fz", 0, 0);
    chk("midrst_qz", 1, 0);
    tick();
    QRTN = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) begin
      cif.CFG_VLD = 1'b1;
      cif.CFG_DI = 1'b1;
      tick();
      cif.CFG_VLD = 1'b0;
      tick();
    end
    chk("vld_only_busy", 3, 0);
    chk("vld_only_fz", 0, 0);
    LI = 16'hFFFF;
    chk("vld_only_fz_ff", 0, 0);
    tick();
    LI = 16'h1231;
    CI = 1'b1;
    load(c_carry, 1'b0);
    chk("carry_pre_commit_fz", 0, 0);
    tick();
`ifdef LOGIC_CLUSTER_CARRY_EN
    chk("carry_b_6_1_fz", 0, 4'h2);
    chk("carry_b_6_1_co", 2, 1);
`else
    chk("nocarry_fz", 0, 0);
    chk("nocarry_co", 2, 0);
`endif
    tick();
    LI = 16'h0211;
    CI = 1'b0;
`ifdef LOGIC_CLUSTER_CARRY_EN
    chk("carry_3_4_fz", 0, 4'h7);
    chk("carry_3_4_co", 2, 0);
`else
    chk("nocarry_co2", 2, 0);
`endif
    tick();
    LI = 16'h1111;
    CI = 1'b1;
`ifdef LOGIC_CLUSTER_CARRY_EN
    chk("carry_ripple_fz", 0, 4'h0);
    chk("carry_ripple_co", 2, 1);
`else
    chk("nocarry_ripple_fz", 0, 0);
`endif
    tick();
    CI = 1'b0;
    load(c_cds, 1'b0);
    tick();
    tick();
    QDI = 4'hF;
    QEN = 4'hF;
    QST = 1'b1;
    QRT = 1'b1;
    tick();
    chk("ff_rt_over_st", 1, 4'h0);
    QRT = 1'b0;
    tick();
    chk("ff_st", 1, 4'hF);
    QST = 1'b0;
    QEN = 4'h0;
    QDI = 4'h0;
    tick();
    chk("ff_hold", 1, 4'hF);
    QEN = 4'hF;
    QDI = 4'h5;
    tick();
    chk("ff_qdi", 1, 4'h5);
    QEN = 4'h3;
    QDI = 4'hA;
    tick();
    chk("ff_partial_en", 1, 4'h6);
    tick();
    tick();
    if (dq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_missing: got %0d pending loads want 0", dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
